// File: rtl/noc_endpoint_if.sv
// noc_endpoint_if: descriptor, injection and ejection signals for router local port 0.
// Latency: wires only, no state.
// Backpressure: desc_ready throttles descriptors; can_inject/inj_take pace injection.
// Ports:   desc_valid/desc_ready/desc_dst/desc_vc/desc_len  descriptor handshake
//          can_inject/inj_take/inj_word                     port-0 input staging
//          ej_strobe/ej_word                                port-0 output staging
// Modports: master = router/traffic side, slave = endpoint side.
interface noc_endpoint_if #(
  parameter int VC_W  = 5,
  parameter int BUF_W = 22
) ();
  logic             desc_valid;
  logic             desc_ready;
  logic [13:0]      desc_dst;
  logic [VC_W-1:0]  desc_vc;
  logic [3:0]       desc_len;
  logic [31:0]      can_inject;
  logic             inj_take;
  logic [BUF_W-1:0] inj_word;
  logic             ej_strobe;
  logic [BUF_W-1:0] ej_word;

  modport master (
    output desc_valid, desc_dst, desc_vc, desc_len,
    output can_inject, inj_take, ej_strobe, ej_word,
    input  desc_ready, inj_word
  );

  modport slave (
    input  desc_valid, desc_dst, desc_vc, desc_len,
    input  can_inject, inj_take, ej_strobe, ej_word,
    output desc_ready, inj_word
  );
endinterface

// File: rtl/noc_endpoint.sv
// noc_endpoint: NoC port-0 endpoint; descriptors -> head/body/tail flits, ejection framing check + counters.
// Latency: descriptor accepted in N gives a head word in N+3; 2 cycles minimum between flits after inj_take.
// Backpressure: desc_ready low when the descriptor FIFO is full; flits wait for can_inject[vc] and inj_take.
// Ports: clk, rst (synchronous, active high); bus (noc_endpoint_if.slave);
//        rx_flits/rx_pkts/tx_pkts wrapping counters; err_frame sticky; err_misroute sticky;
//        idle = FIFO empty, FSM idle, staging word empty.
// Option: NOC_EP_DST_CHECK_EN enables the ejected-dst == MY_ADDR check; otherwise err_misroute is 0.
module noc_endpoint #(
  parameter int          VC_W     = 5,
  parameter int          FLIT_W   = 16,
  parameter int          BUF_W    = 22,
  parameter logic [13:0] MY_ADDR  = 14'h0,
  parameter int          DQ_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  noc_endpoint_if.slave  bus,
  output logic [15:0]    rx_flits,
  output logic [15:0]    rx_pkts,
  output logic [15:0]    tx_pkts,
  output logic           err_frame,
  output logic           err_misroute,
  output logic           idle
);
  localparam int AW     = $clog2(DQ_DEPTH);
  localparam int NVC    = 1 << VC_W;
  localparam int FULL_B = BUF_W - 1;
  localparam int TAIL_B = FLIT_W - 1;
  localparam int HEAD_B = FLIT_W - 2;

  typedef struct packed {
    logic [13:0]     dst;
    logic [VC_W-1:0] vc;
    logic [3:0]      len;
  } desc_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PRESENT} state_t;

  // ---------------- descriptor FIFO ----------------
  desc_t       mem [DQ_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;
  state_t      state;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = bus.desc_valid && !full;
  assign pop   = (state == S_IDLE) && !empty;
  assign bus.desc_ready = !full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{dst: bus.desc_dst, vc: bus.desc_vc, len: bus.desc_len};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- injection FSM ----------------
  logic [13:0]      cur_dst;
  logic [VC_W-1:0]  cur_vc;
  logic [3:0]       rem;
  logic             first;
  logic [BUF_W-1:0] inj_q;
  desc_t            head_desc;

  assign head_desc    = mem[rd_ptr[AW-1:0]];
  assign bus.inj_word = inj_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cur_dst <= '0;
      cur_vc  <= '0;
      rem     <= '0;
      first   <= 1'b0;
      inj_q   <= '0;
      tx_pkts <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            cur_dst <= head_desc.dst;
            cur_vc  <= head_desc.vc;
            rem     <= head_desc.len;
            first   <= 1'b1;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Permission is re-sampled for every flit, not just the head.
          if (bus.can_inject[cur_vc]) begin
            inj_q <= {1'b1, cur_vc, (rem == 4'd0), first, cur_dst};
            state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (bus.inj_take) begin
            inj_q <= '0;
            if (rem == 4'd0) begin
              tx_pkts <= tx_pkts + 16'd1;
              state   <= S_IDLE;
            end else begin
              rem   <= rem - 4'd1;
              first <= 1'b0;
              state <= S_WAIT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign idle = empty && (state == S_IDLE) && !inj_q[FULL_B];

  // ---------------- ejection ----------------
  logic            ej_ev, ej_head, ej_tail;
  logic [VC_W-1:0] ej_vc;
  logic [NVC-1:0]  in_pkt;

  assign ej_ev   = bus.ej_strobe && bus.ej_word[FULL_B];
  assign ej_vc   = bus.ej_word[FLIT_W +: VC_W];
  assign ej_head = bus.ej_word[HEAD_B];
  assign ej_tail = bus.ej_word[TAIL_B];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_flits  <= '0;
      rx_pkts   <= '0;
      err_frame <= 1'b0;
      in_pkt    <= '0;
    end else if (ej_ev) begin
      rx_flits <= rx_flits + 16'd1;
      if (ej_tail) rx_pkts <= rx_pkts + 16'd1;
      if (ej_head == in_pkt[ej_vc]) err_frame <= 1'b1;
      // Tail wins, so a head+tail flit leaves the VC out of a packet.
      if (ej_tail)      in_pkt[ej_vc] <= 1'b0;
      else if (ej_head) in_pkt[ej_vc] <= 1'b1;
    end
  end

`ifdef NOC_EP_DST_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                                          err_misroute <= 1'b0;
    else if (ej_ev && (bus.ej_word[13:0] != MY_ADDR)) err_misroute <= 1'b1;
  end
`else
  logic unused_dst_chk;
  assign unused_dst_chk = ^{bus.ej_word[13:0], MY_ADDR};
  assign err_misroute   = 1'b0;
`endif
endmodule

// File: tb/tb_noc_endpoint.sv
// tb_noc_endpoint: directed bench for noc_endpoint; injection, FIFO fill, reset, ejection framing.
// Latency: inputs driven and outputs checked on the falling edge.
// Backpressure: exercised through can_inject stalls and a full descriptor FIFO.
module tb_noc_endpoint;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rx_flits, rx_pkts, tx_pkts;
  logic        err_frame, err_misroute, idle;
  int          checks = 0;
  int          errors = 0;

`ifdef NOC_EP_DST_CHECK_EN
  localparam logic [31:0] MISR_EXP = 32'd1;
`else
  localparam logic [31:0] MISR_EXP = 32'd0;
`endif

  noc_endpoint_if #(.VC_W(5), .BUF_W(22)) bus ();

  noc_endpoint dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .rx_flits     (rx_flits),
    .rx_pkts      (rx_pkts),
    .tx_pkts      (tx_pkts),
    .err_frame    (err_frame),
    .err_misroute (err_misroute),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic eject(input logic [21:0] w);
    bus.ej_strobe = 1'b1;
    bus.ej_word   = w;
    tick();
    bus.ej_strobe = 1'b0;
    bus.ej_word   = '0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.desc_valid = 1'b0;
    bus.desc_dst   = '0;
    bus.desc_vc    = '0;
    bus.desc_len   = '0;
    bus.can_inject = '0;
    bus.inj_take   = 1'b0;
    bus.ej_strobe  = 1'b0;
    bus.ej_word    = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_inj_word", {10'd0, bus.inj_word}, 32'h0);
    chk("rst_desc_ready", {31'd0, bus.desc_ready}, 32'd1);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_rx_flits", {16'd0, rx_flits}, 32'd0);
    chk("rst_rx_pkts", {16'd0, rx_pkts}, 32'd0);
    chk("rst_tx_pkts", {16'd0, tx_pkts}, 32'd0);
    chk("rst_err_frame", {31'd0, err_frame}, 32'd0);
    chk("rst_err_misroute", {31'd0, err_misroute}, 32'd0);

    // Single-flit packet dst=5 vc=1
    bus.can_inject = 32'h2;
    bus.desc_valid = 1'b1; bus.desc_dst = 14'd5; bus.desc_vc = 5'd1; bus.desc_len = 4'd0;
    tick();                                   // N+1
    bus.desc_valid = 1'b0;
    chk("t1_idle_busy", {31'd0, idle}, 32'd0);
    chk("t1_word_n1", {10'd0, bus.inj_word}, 32'h0);
    tick();                                   // N+2 (WAIT)
    chk("t1_word_n2", {10'd0, bus.inj_word}, 32'h0);
    tick();                                   // N+3
    chk("t1_head", {10'd0, bus.inj_word}, 32'h21C005);
    tick();
    chk("t1_hold", {10'd0, bus.inj_word}, 32'h21C005);
    bus.inj_take = 1'b1;
    tick();
    bus.inj_take = 1'b0;
    chk("t1_cleared", {10'd0, bus.inj_word}, 32'h0);
    chk("t1_tx_pkts", {16'd0, tx_pkts}, 32'd1);
    chk("t1_idle", {31'd0, idle}, 32'd1);

    // 3-flit packet dst=9 vc=0, stall before flit 2
    bus.can_inject = 32'h1;
    bus.desc_valid = 1'b1; bus.desc_dst = 14'd9; bus.desc_vc = 5'd0; bus.desc_len = 4'd2;
    tick();
    bus.desc_valid = 1'b0;
    tick();
    tick();
    chk("t2_head", {10'd0, bus.inj_word}, 32'h204009);
    bus.inj_take   = 1'b1;
    bus.can_inject = 32'h0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_stall", {10'd0, bus.inj_word}, 32'h0);
      bus.inj_take = (i == 1);                // take in WAIT must be ignored
      tick();
    end
    bus.inj_take = 1'b0;
    chk("t2_stall_end", {10'd0, bus.inj_word}, 32'h0);
    bus.can_inject = 32'h1;
    tick();
    chk("t2_body", {10'd0, bus.inj_word}, 32'h200009);
    bus.inj_take = 1'b1;
    tick();
    bus.inj_take = 1'b0;
    chk("t2_gap", {10'd0, bus.inj_word}, 32'h0);
    tick();
    chk("t2_tail", {10'd0, bus.inj_word}, 32'h208009);
    bus.inj_take = 1'b1;
    tick();
    bus.inj_take = 1'b0;
    chk("t2_cleared", {10'd0, bus.inj_word}, 32'h0);
    chk("t2_tx_pkts", {16'd0, tx_pkts}, 32'd2);
    chk("t2_idle", {31'd0, idle}, 32'd1);

    // FIFO fill: 5 back-to-back pushes with injection blocked
    bus.can_inject = 32'h0;
    for (int i = 0; i < 5; i++) begin
      bus.desc_valid = 1'b1;
      bus.desc_dst   = 14'(i + 1);
      bus.desc_vc    = 5'd3;
      bus.desc_len   = 4'd0;
      chk("t3_ready_before_push", {31'd0, bus.desc_ready}, 32'd1);
      tick();
    end
    bus.desc_dst = 14'd6;                     // sixth offer must be refused
    chk("t3_ready_full", {31'd0, bus.desc_ready}, 32'd0);
    tick();
    bus.desc_valid = 1'b0;
    chk("t3_still_full", {31'd0, bus.desc_ready}, 32'd0);
    chk("t3_idle_full", {31'd0, idle}, 32'd0);
    bus.can_inject = 32'hFFFF_FFFF;
    for (int p = 0; p < 5; p++) begin
      int n;
      n = 0;
      while (bus.inj_word[21] !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      chk("t3_drain_timeout", {31'd0, (n < 10)}, 32'd1);
      chk("t3_drain_word", {10'd0, bus.inj_word}, 32'h23C000 + 32'(p + 1));
      bus.inj_take = 1'b1;
      tick();
      bus.inj_take = 1'b0;
    end
    chk("t3_tx_pkts", {16'd0, tx_pkts}, 32'd7);
    chk("t3_idle", {31'd0, idle}, 32'd1);

    // Reset mid-packet drops current packet and queued descriptors
    bus.desc_valid = 1'b1; bus.desc_dst = 14'd7; bus.desc_vc = 5'd3; bus.desc_len = 4'd1;
    tick();
    bus.desc_dst = 14'd8;
    tick();
    bus.desc_valid = 1'b0;
    tick();
    chk("t4_head", {10'd0, bus.inj_word}, 32'h234007);
    rst = 1'b1;
    tick();
    chk("t4_rst_word", {10'd0, bus.inj_word}, 32'h0);
    chk("t4_rst_tx", {16'd0, tx_pkts}, 32'd0);
    chk("t4_rst_ready", {31'd0, bus.desc_ready}, 32'd1);
    chk("t4_rst_idle", {31'd0, idle}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_no_stale_word", {10'd0, bus.inj_word}, 32'h0);
    chk("t4_no_stale_idle", {31'd0, idle}, 32'd1);

    // Ejection: head/body/tail on vc2 with a full=0 strobe in between
    eject(22'h224000);
    chk("t5_rx_head", {16'd0, rx_flits}, 32'd1);
    eject(22'h024000);
    chk("t5_rx_ignored", {16'd0, rx_flits}, 32'd1);
    eject(22'h220000);
    eject(22'h228000);
    chk("t5_rx_flits", {16'd0, rx_flits}, 32'd3);
    chk("t5_rx_pkts", {16'd0, rx_pkts}, 32'd1);
    chk("t5_err_frame", {31'd0, err_frame}, 32'd0);

    // Single-flit eject dst=3 vc0: misroute only when the check is built in
    eject(22'h20C003);
    chk("t6_rx_flits", {16'd0, rx_flits}, 32'd4);
    chk("t6_rx_pkts", {16'd0, rx_pkts}, 32'd2);
    chk("t6_err_frame", {31'd0, err_frame}, 32'd0);
    chk("t6_misroute", {31'd0, err_misroute}, MISR_EXP);

    // Body with no prior head on vc4: sticky framing error
    eject(22'h240000);
    chk("t7_err_frame", {31'd0, err_frame}, 32'd1);
    tick();
    tick();
    eject(22'h244000);
    chk("t7_err_sticky", {31'd0, err_frame}, 32'd1);
    chk("t7_rx_flits", {16'd0, rx_flits}, 32'd6);
    chk("t7_misroute_sticky", {31'd0, err_misroute}, MISR_EXP);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_err_cleared", {31'd0, err_frame}, 32'd0);
    chk("t7_misroute_cleared", {31'd0, err_misroute}, 32'd0);
    chk("t7_rx_cleared", {16'd0, rx_flits}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
